femto_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that answers CPU stores and loads on the FemtoRV32 IO bus inside femtosoc.
- Bytes written by firmware are buffered in a small FIFO and serialized 8N1 on `tx`.
- The console/pass-fail output path for the simulation testbench and for the board. It replaces ad-hoc store snooping on `mem_addr`/`mem_wdata`.

---
 rtl/femto_io_pkg.sv | 28 ++
 rtl/femto_uart_tx_if.sv | 29 ++
 rtl/femto_fifo.sv | 72 +++++++
 rtl/femto_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_femto_uart_tx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/femto_io_pkg.sv
// femto_io_pkg
// Shared definitions for the FemtoRV32 IO peripherals inside femtosoc:
// register offsets on the word-address select line, STATUS bit positions
// and the UART serializer state encoding.
// No ports (package).

package femto_io_pkg;

    // Register select values on mem_addr (word address bit 2)
    localparam logic DATA_OFS   = 1'b0;
    localparam logic STATUS_OFS = 1'b1;

    // STATUS register bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // Serializer states; explicit encodings keep the register image stable
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/femto_uart_tx_if.sv
// femto_uart_tx_if
// IO bus bundle between the FemtoRV32 core's IO decode and a peripheral.
// Signals:
//   sel        IO decode hit for the peripheral
//   mem_addr   register select (0 = DATA, 1 = STATUS)
//   mem_wdata  store data
//   mem_wmask  byte write strobes, one-cycle pulse per store
//   mem_rstrb  load strobe, one-cycle pulse
//   mem_rdata  registered load data
// Modports: master = CPU side, slave = peripheral side.

interface femto_uart_tx_if;
    logic        sel;
    logic        mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;

    modport master (
        output sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata
    );

    modport slave (
        input  sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata
    );
endinterface

// File: rtl/femto_fifo.sv
// femto_fifo
// Small synchronous FIFO with a combinational head output (rdata shows the
// oldest entry whenever empty=0). Shared by the UART transmitter and any
// future receiver.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (flushes the FIFO)
//   push, wdata     enqueue request and data
//   pop             dequeue request
//   rdata           head entry
//   full, empty     occupancy flags
//   count           number of stored entries (clog2(DEPTH)+1 bits)
// A push while full is only accepted when a pop happens in the same cycle;
// a pop while empty is ignored.

module femto_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // Storage needs no reset: the pointers and count decide what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/femto_uart_tx.sv
// femto_uart_tx
// Memory-mapped 8N1 UART transmitter on the FemtoRV32 IO bus. Stores to DATA
// queue a byte in a small FIFO; the serializer drains it onto tx. STATUS
// reports full/empty/busy/sticky-overflow/count and clears overflow on read.
// Ports:
//   pclk       system clock
//   RESET      asynchronous active-high reset
//   bus        IO bus (slave modport): sel, mem_addr, mem_wdata, mem_wmask,
//              mem_rstrb in; mem_rdata out (registered, 1-cycle latency)
//   tx         serial line, idle high, driven from a register
//   irq_empty  high while the FIFO is empty and the serializer is idle

module femto_uart_tx
    import femto_io_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           pclk,
    input  logic           RESET,
    femto_uart_tx_if.slave bus,
    output logic           tx,
    output logic           irq_empty
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

    tx_state_e        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             overflow;
    logic [31:0]      rdata_q;
    logic [31:0]      status_word;

    logic             store_data;
    logic             load_req;
    logic             ovf_event;
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    // Only byte lane 0 of a DATA store carries the character
    logic             unused_bus_bits;
    assign unused_bus_bits = ^{bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

    assign store_data = bus.sel & (bus.mem_addr == DATA_OFS) & bus.mem_wmask[0];
    assign load_req   = bus.sel & bus.mem_rstrb;
    assign fifo_pop   = (state == IDLE) & ~fifo_empty;
    assign ovf_event  = store_data & fifo_full & ~fifo_pop;
    assign irq_empty  = fifo_empty & (state == IDLE);
    assign bus.mem_rdata = rdata_q;

    femto_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (RESET),
        .push  (store_data),
        .wdata (bus.mem_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // STATUS image as seen by a load in this cycle
    always_comb begin
        status_word                        = '0;
        status_word[STAT_FULL]             = fifo_full;
        status_word[STAT_EMPTY]            = fifo_empty;
        status_word[STAT_BUSY]             = (state != IDLE);
        status_word[STAT_OVF]              = overflow;
        status_word[STAT_CNT_LSB +: 4]     = 4'(fifo_count);
    end

    // Load data capture and sticky overflow; a same-cycle overflow wins
    // over the clear-on-read so no event is ever lost
    always_ff @(posedge pclk or posedge RESET) begin
        if (RESET) begin
            rdata_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (load_req) begin
                rdata_q <= (bus.mem_addr == STATUS_OFS) ? status_word : 32'h0;
            end
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (load_req && (bus.mem_addr == STATUS_OFS)) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serializer: each of START, 8 DATA bits and STOP lasts DIV cycles,
    // counted down from DIV-1; IDLE always spends one cycle popping
    always_ff @(posedge pclk or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= fifo_rdata;
                        baud_cnt  <= DIV_M1;
                        bit_idx   <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_M1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt  <= DIV_M1;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // tx follows the state one cycle later from a flop, so the line never
    // glitches on state decode; the lag is uniform across the frame
    always_ff @(posedge pclk or posedge RESET) begin
        if (RESET) begin
            tx <= 1'b1;
        end else begin
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift_reg[0];
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_femto_uart_tx.sv
// tb_femto_uart_tx
// Self-checking bench for femto_uart_tx with DIV=4 (1 MHz clock, 250 kbaud).
// Stimulus pushes expected load data and expected serial frames (byte plus
// start cycle) into queues; two monitors pop and compare when the DUT
// answers a load or draws a frame on tx.

module tb_femto_uart_tx;
    import femto_io_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         startCyc;
    } frame_t;

    logic pclk = 1'b0;
    logic RESET;
    logic tx;
    logic irq_empty;

    femto_uart_tx_if bus ();

    femto_uart_tx #(
        .CLK_FREQ   (1000000),
        .BAUD       (250000),
        .FIFO_DEPTH (4)
    ) dut (
        .pclk      (pclk),
        .RESET     (RESET),
        .bus       (bus),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;
    logic [31:0] rdExp[$];
    frame_t      txExp[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic busWrite(input logic sel, input logic addr, input logic [31:0] wdata,
                            input logic [3:0] wmask, output int edgeCyc);
        bus.sel       = sel;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wmask = wmask;
        @(negedge pclk);
        edgeCyc       = cyc;
        bus.sel       = 1'b0;
        bus.mem_wmask = 4'h0;
        bus.mem_wdata = 32'h0;
    endtask

    task automatic busRead(input logic addr, input logic [31:0] expected);
        rdExp.push_back(expected);
        bus.sel       = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_rstrb = 1'b1;
        @(negedge pclk);
        bus.sel       = 1'b0;
        bus.mem_rstrb = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic waitFramesDone(input int limit);
        int i;
        i = 0;
        while (txExp.size() != 0 && i < limit) begin
            @(negedge pclk);
            i++;
        end
        checkOutput("frames drained", 32'(txExp.size()), 32'h0);
        txExp.delete();
    endtask

    // Load monitor: one cycle after a selected load strobe, mem_rdata must
    // hold the value queued when the load was issued
    initial begin
        forever begin
            @(posedge pclk);
            if (bus.sel === 1'b1 && bus.mem_rstrb === 1'b1 && RESET === 1'b0) begin
                #1;
                if (rdExp.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected load: got 0x%08h expected none", bus.mem_rdata);
                end else begin
                    checkOutput("load data", bus.mem_rdata, rdExp.pop_front());
                end
            end
        end
    end

    // Line monitor: a low tx starts a 40-sample frame; start bits low, each
    // data bit constant for 4 samples, stop high. Frames cut by RESET are dropped.
    initial begin
        logic [7:0] data;
        logic       ok;
        logic       aborted;
        int         startCyc;
        frame_t     exp;
        forever begin
            @(negedge pclk);
            if (RESET === 1'b0 && tx === 1'b0) begin
                startCyc = cyc;
                ok       = 1'b1;
                aborted  = 1'b0;
                data     = 8'h0;
                for (int i = 0; i < 40; i++) begin
                    if (i > 0) @(negedge pclk);
                    if (RESET !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i < 4) begin
                        if (tx !== 1'b0) ok = 1'b0;
                    end else if (i < 36) begin
                        if (((i - 4) % 4) == 0) data[(i - 4) / 4] = tx;
                        else if (tx !== data[(i - 4) / 4]) ok = 1'b0;
                    end else begin
                        if (tx !== 1'b1) ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (txExp.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpected frame: got 0x%02h at cycle %0d expected none",
                                 data, startCyc);
                    end else begin
                        exp = txExp.pop_front();
                        checkOutput("frame byte", 32'(data), 32'(exp.data));
                        checkOutput("frame start cycle", 32'(startCyc), 32'(exp.startCyc));
                        checkOutput("frame shape", 32'(ok), 32'h1);
                    end
                end
            end
        end
    end

    task automatic applyStimulus();
        int s;
        int s0;
        int dummy;

        // Reset state, during and after reset
        RESET         = 1'b1;
        bus.sel       = 1'b0;
        bus.mem_addr  = 1'b0;
        bus.mem_wdata = 32'h0;
        bus.mem_wmask = 4'h0;
        bus.mem_rstrb = 1'b0;
        waitCycles(3);
        checkOutput("tx in reset", 32'(tx), 32'h1);
        checkOutput("rdata in reset", bus.mem_rdata, 32'h0);
        checkOutput("irq_empty in reset", 32'(irq_empty), 32'h1);
        RESET = 1'b0;
        waitCycles(1);
        checkOutput("tx after reset", 32'(tx), 32'h1);
        checkOutput("rdata after reset", bus.mem_rdata, 32'h0);
        busRead(STATUS_OFS, 32'h0000_0002);

        // Single byte: frame starts 2 cycles after the store edge, busy mid-frame
        busWrite(1'b1, DATA_OFS, 32'hDEAD_BE55, 4'h1, s);
        txExp.push_back('{8'h55, s + 2});
        waitCycles(4);
        busRead(STATUS_OFS, 32'h0000_0006);
        checkOutput("irq_empty mid-frame", 32'(irq_empty), 32'h0);
        while (cyc < s + 42) @(negedge pclk);
        checkOutput("irq_empty after frame", 32'(irq_empty), 32'h1);
        busRead(STATUS_OFS, 32'h0000_0002);
        waitFramesDone(20);

        // Fill and overflow: 0x41 pops at once, 0x42..0x45 fill, 0x46 dropped.
        // BUSY is also set since 0x41 is on the line: full|busy|ovf|cnt4 = 0x4D.
        busWrite(1'b1, DATA_OFS, 32'h41, 4'h1, s0);
        for (int b = 8'h42; b <= 8'h46; b++) begin
            busWrite(1'b1, DATA_OFS, 32'(b), 4'hF, dummy);
        end
        for (int k = 0; k < 5; k++) begin
            txExp.push_back('{8'(8'h41 + k), s0 + 2 + 41 * k});
        end
        busRead(STATUS_OFS, 32'h0000_004D);
        busRead(STATUS_OFS, 32'h0000_0045);

        // Store lands on the edge the FSM pops 0x42 (s0+42): accepted while full
        while (cyc < s0 + 41) @(negedge pclk);
        busWrite(1'b1, DATA_OFS, 32'h47, 4'h1, dummy);
        txExp.push_back('{8'h47, s0 + 2 + 41 * 5});
        busRead(STATUS_OFS, 32'h0000_0045);
        waitFramesDone(400);
        busRead(STATUS_OFS, 32'h0000_0002);

        // Masking and decode: none of these may enqueue
        busWrite(1'b1, DATA_OFS,   32'h5A, 4'b0010, dummy);
        busWrite(1'b0, DATA_OFS,   32'h5B, 4'hF,    dummy);
        busWrite(1'b1, STATUS_OFS, 32'h5C, 4'hF,    dummy);
        busRead(STATUS_OFS, 32'h0000_0002);
        waitCycles(60);
        busRead(DATA_OFS, 32'h0000_0000);
        checkOutput("irq_empty after ignored stores", 32'(irq_empty), 32'h1);

        // Reset mid-frame: the 0x00 frame is aborted and never completes
        busWrite(1'b1, DATA_OFS, 32'h00, 4'h1, s);
        busRead(STATUS_OFS, 32'h0000_0010);
        waitCycles(8);
        checkOutput("tx low mid-frame", 32'(tx), 32'h0);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("tx on async reset", 32'(tx), 32'h1);
        checkOutput("irq_empty on async reset", 32'(irq_empty), 32'h1);
        waitCycles(2);
        RESET = 1'b0;
        waitCycles(1);
        checkOutput("rdata after mid-frame reset", bus.mem_rdata, 32'h0);
        busRead(STATUS_OFS, 32'h0000_0002);
        waitCycles(60);
        checkOutput("tx idle after flush", 32'(tx), 32'h1);
        checkOutput("scoreboard empty", 32'(txExp.size() + rdExp.size()), 32'h0);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
